// File: rtl/onehot8_enc_pkg.sv
// Shared definitions for the one-hot event encoder.
//   NUM_LINES  : number of event lines (8)
//   CODE_PAD_W : zero padding above the 3-bit index in the output code
//   idx_t      : 3-bit event index
//   idx_onehot : index -> one-hot mask helper
package onehot8_enc_pkg;

  localparam int NUM_LINES  = 8;
  localparam int CODE_PAD_W = 5;

  typedef logic [2:0] idx_t;

  function automatic logic [NUM_LINES-1:0] idx_onehot(input idx_t i);
    logic [NUM_LINES-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot8_prio_pick.sv
// Combinational priority picker over eight request bits.
// The search starts at index 'base' and wraps 7 -> 0; the first set request
// found is returned.
//   req  in  8  request mask
//   base in  3  first index searched
//   any  out 1  at least one request set
//   idx  out 3  chosen index (equals base when no request is set)
module onehot8_prio_pick
  import onehot8_enc_pkg::*;
(
  input  logic [NUM_LINES-1:0] req,
  input  idx_t                 base,
  output logic                 any,
  output idx_t                 idx
);

  idx_t cand;

  // Walk from the farthest offset down to offset 0 so the nearest request
  // to base is the one left standing.
  always_comb begin
    any  = 1'b0;
    idx  = base;
    cand = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      cand = base + idx_t'(i);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/onehot8_event_encoder.sv
// Eight single-bit event lines -> registered 3-bit index on an 8-bit bus.
// Rising edges are captured into Pending and emitted one per handshake.
// Optional macro ONEHOT8_ENC_ROUND_ROBIN_EN selects rotating priority
// (search starts after the last loaded index); default is fixed priority,
// lowest index first.
//   clk, rst            clock, synchronous active-high reset
//   Input_1 .. Input_8  event lines, Input_k -> index k-1
//   Ready               consumer takes Output this cycle
//   Clear               clears Overflow
//   Output [7:0]        {5'b0, index}
//   Valid               Output holds an unconsumed event
//   Overflow            sticky lost-event flag
//   Pending [7:0]       captured events not yet loaded into Output
module onehot8_event_encoder
  import onehot8_enc_pkg::*;
#(
  parameter int    UUID = 0,
  parameter string NAME = ""
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Input_1,
  input  logic       Input_2,
  input  logic       Input_3,
  input  logic       Input_4,
  input  logic       Input_5,
  input  logic       Input_6,
  input  logic       Input_7,
  input  logic       Input_8,
  input  logic       Ready,
  input  logic       Clear,
  output logic [7:0] Output,
  output logic       Valid,
  output logic       Overflow,
  output logic [7:0] Pending
);

  logic [NUM_LINES-1:0] in_vec;
  logic [NUM_LINES-1:0] prev_q, prev_d;
  logic [NUM_LINES-1:0] pending_q, pending_d;
  logic [NUM_LINES-1:0] rise, moved;
  idx_t                 code_q, code_d;
  logic                 valid_q, valid_d;
  logic                 overflow_q, overflow_d;
  logic                 load, pick_any;
  idx_t                 pick_idx, pick_base;

  assign in_vec = {Input_8, Input_7, Input_6, Input_5,
                   Input_4, Input_3, Input_2, Input_1};

`ifdef ONEHOT8_ENC_ROUND_ROBIN_EN
  idx_t last_q, last_d;
  // last_q resets to 7 so the first search begins at index 0.
  assign pick_base = last_q + 3'd1;
`else
  assign pick_base = '0;
`endif

  onehot8_prio_pick u_pick (
    .req  (pending_q),
    .base (pick_base),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    prev_d = in_vec;
    rise   = in_vec & ~prev_q;
    // The output register is free when empty or being consumed this cycle.
    load   = ~valid_q | Ready;
    moved  = (load && pick_any) ? idx_onehot(pick_idx) : '0;
    // A fresh edge on the bit being moved re-arms it as a new event.
    pending_d  = (pending_q & ~moved) | rise;
    overflow_d = (overflow_q & ~Clear) | (|(rise & pending_q & ~moved));
    valid_d    = load ? pick_any : valid_q;
    code_d     = (load && pick_any) ? pick_idx : code_q;
  end

`ifdef ONEHOT8_ENC_ROUND_ROBIN_EN
  always_comb begin
    last_d = (load && pick_any) ? pick_idx : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 3'd7;
    else     last_q <= last_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= '0;
      pending_q  <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      pending_q  <= pending_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign Output   = {{CODE_PAD_W{1'b0}}, code_q};
  assign Valid    = valid_q;
  assign Overflow = overflow_q;
  assign Pending  = pending_q;

endmodule

// File: tb/tb_onehot8_event_encoder.sv
module tb_onehot8_event_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_vec;
  logic       ready, clear;
  logic [7:0] dut_out, dut_pend;
  logic       dut_vld, dut_ovf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic [7:0] in;
    logic       rdy;
    logic       clr;
    logic [7:0] e_out;
    logic       e_vld;
    logic [7:0] e_pend;
    logic       e_ovf;
  } vec_t;

  typedef struct {
    logic [7:0] e_out;
    logic       e_vld;
    logic [7:0] e_pend;
    logic       e_ovf;
    string      tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  onehot8_event_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .Input_1  (in_vec[0]),
    .Input_2  (in_vec[1]),
    .Input_3  (in_vec[2]),
    .Input_4  (in_vec[3]),
    .Input_5  (in_vec[4]),
    .Input_6  (in_vec[5]),
    .Input_7  (in_vec[6]),
    .Input_8  (in_vec[7]),
    .Ready    (ready),
    .Clear    (clear),
    .Output   (dut_out),
    .Valid    (dut_vld),
    .Overflow (dut_ovf),
    .Pending  (dut_pend)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, then compare after the edge.
  task automatic cyc(input string tag, input logic r, input logic [7:0] i,
                     input logic rd, input logic cl, input logic [7:0] eo,
                     input logic ev, input logic [7:0] ep, input logic eovf);
    exp_t e;
    @(negedge clk);
    rst    = r;
    in_vec = i;
    ready  = rd;
    clear  = cl;
    sb.push_back('{eo, ev, ep, eovf, tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".out"},  dut_out,          e.e_out);
    check({e.tag, ".vld"},  {7'b0, dut_vld},  {7'b0, e.e_vld});
    check({e.tag, ".pend"}, dut_pend,         e.e_pend);
    check({e.tag, ".ovf"},  {7'b0, dut_ovf},  {7'b0, e.e_ovf});
  endtask

  initial begin
    logic [7:0] code_a, code_b, pend_a;
`ifdef ONEHOT8_ENC_ROUND_ROBIN_EN
    code_a = 8'h01; pend_a = 8'h01; code_b = 8'h00;
`else
    code_a = 8'h00; pend_a = 8'h02; code_b = 8'h01;
`endif
    rst = 1'b1; in_vec = '0; ready = 1'b0; clear = 1'b0;

    //               rst in     rdy   clr   out    vld   pend   ovf
    tbl.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0}); // reset
    tbl.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h04, 1'b1, 1'b0, 8'h00, 1'b0, 8'h04, 1'b0}); // Input_3 pulse
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0}); // reset
    tbl.push_back('{1'b0, 8'h92, 1'b0, 1'b0, 8'h00, 1'b0, 8'h92, 1'b0}); // Input_8,2,5
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 8'h90, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 8'h90, 1'b0}); // stall
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h04, 1'b1, 8'h80, 1'b0}); // back-to-back
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h07, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h07, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h08, 1'b0, 1'b0, 8'h07, 1'b0, 8'h08, 1'b0}); // Input_4 #1
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h08, 1'b0, 1'b0, 8'h03, 1'b1, 8'h08, 1'b0}); // #2: shown idx
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 8'h08, 1'b0});
    tbl.push_back('{1'b0, 8'h08, 1'b0, 1'b0, 8'h03, 1'b1, 8'h08, 1'b1}); // #3: overflow
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b1, 8'h08, 1'b0}); // Clear
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 8'h20, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0}); // Input_6 held
    tbl.push_back('{1'b0, 8'h20, 1'b1, 1'b0, 8'h00, 1'b0, 8'h20, 1'b0});
    tbl.push_back('{1'b0, 8'h20, 1'b1, 1'b0, 8'h05, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h20, 1'b1, 1'b0, 8'h05, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h20, 1'b1, 1'b0, 8'h05, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h10, 1'b0, 1'b0, 8'h05, 1'b0, 8'h10, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h30, 1'b0, 1'b0, 8'h04, 1'b1, 8'h30, 1'b0});
    tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0}); // rst mid-transfer
    tbl.push_back('{1'b0, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0});
    tbl.push_back('{1'b0, 8'h01, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0}); // edge during move
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h02, 1'b0, 1'b0, 8'h01, 1'b1, 8'h02, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 8'h02, 1'b0});
    tbl.push_back('{1'b0, 8'h02, 1'b0, 1'b0, 8'h01, 1'b1, 8'h02, 1'b1}); // overflow
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 8'h02, 1'b1}); // sticky
    tbl.push_back('{1'b0, 8'h02, 1'b0, 1'b1, 8'h01, 1'b1, 8'h02, 1'b1}); // Clear vs new ovf
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b1, 8'h02, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 8'h00, 1'b0});

    foreach (tbl[k]) begin
      cyc($sformatf("row%0d", k), tbl[k].rst, tbl[k].in, tbl[k].rdy, tbl[k].clr,
          tbl[k].e_out, tbl[k].e_vld, tbl[k].e_pend, tbl[k].e_ovf);
    end

    // Priority order: Input_1 shown, then Input_1 and Input_2 pulse together.
    cyc("pri_rst",  1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    cyc("pri_p1",   1'b0, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0);
    cyc("pri_ld",   1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    cyc("pri_p12",  1'b0, 8'h03, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0);
    cyc("pri_hold", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0);
    cyc("pri_a",    1'b0, 8'h00, 1'b1, 1'b0, code_a, 1'b1, pend_a, 1'b0);
    cyc("pri_b",    1'b0, 8'h00, 1'b1, 1'b0, code_b, 1'b1, 8'h00, 1'b0);
    cyc("pri_end",  1'b0, 8'h00, 1'b1, 1'b0, code_b, 1'b0, 8'h00, 1'b0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onehot8_event_encoder.md
Name: onehot8_event_encoder

Overview:
- Inverse of the 3-to-8 bit decoder: turns eight 1-bit event lines back into a 3-bit index.
- Each line's rising edge is captured in a pending register.
- Pending events are emitted one at a time as a registered code on an 8-bit bus, under a valid/ready handshake.
- Sits between scattered single-bit event sources (IRQ-style lines, decoder outputs) and a byte-wide consumer.

Parameters:
- UUID, 0, instance identifier; XOR-combined into any child UUID.
- NAME, "", instance label; no functional effect.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- Input_1 .. Input_8  in  1 each  event lines; Input_k maps to index k-1
- Ready  in  1  consumer accepts Output this cycle
- Clear  in  1  clears Overflow
- Output  out  8  bits[2:0] = event index, bits[7:3] = 0
- Valid  out  1  Output holds an unconsumed event
- Overflow  out  1  sticky: an event was lost
- Pending  out  8  pending events not yet loaded into Output; bit k-1 = Input_k

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - Output = 8'h00, Valid = 0, Overflow = 0, Pending = 8'h00.
  - Previous-input register = 8'h00, so a line already high after reset yields exactly one event.
- Edge capture: edge[i] = in[i] & ~prev[i]; prev <= in every cycle.
- Load condition: load = ~Valid | (Valid & Ready).
- Load action:
  - If load and (Pending != 0), pick index p; Output <= {5'b0, p}; Valid <= 1; Pending[p] is cleared (moved into Output).
  - If load and Pending == 0, Valid <= 0; Output keeps its last value.
- Pending update, per bit: next = (Pending & ~moved) | edge.
  - A set in the same cycle wins over the move; the bit stays pending as a new event.
- Overflow:
  - Set when edge[i] & Pending[i] & ~moved[i] for any i.
  - Clear deasserts it; a new overflow in the same cycle as Clear wins (stays 1).
- Pick, default: fixed priority, lowest index first (Input_1 highest).
- Latency:
  - An edge present on the inputs before clock edge N appears in Pending after edge N.
  - Output/Valid update after edge N+1 if the register is free: 2 cycles.
- Throughput: with Ready held high and multiple events pending, one new code per cycle, no bubbles.
- Valid stays high and Output stays stable while Ready = 0; no event is dropped except by Overflow.
- An edge on the index currently shown in Output is a new event: it sets Pending, with no overflow.
- rst mid-transfer discards all pending and displayed events; no Overflow.

Optional Feature:
- Macro: ONEHOT8_ENC_ROUND_ROBIN_EN.
- Defined: rotating priority. The search starts at (last_loaded + 1) mod 8 and wraps 7 -> 0. last_loaded resets to 7, so the first search starts at index 0.
- Undefined: fixed lowest-index priority, and no last_loaded register.

Decomposition:
- Package onehot8_enc_pkg holds:
  - NUM_LINES = 8
  - typedef idx_t (logic [2:0])
  - CODE_PAD_W = 5
- Sub-module onehot8_prio_pick: combinational.
  - Inputs: req[7:0], base idx_t.
  - Outputs: any, idx.
  - Base is tied to 0 when the feature is undefined.
- Top holds prev, Pending, Output/Valid, Overflow and the optional last_loaded register.

Test Plan:
- Reset, then pulse Input_3 for 1 cycle with Ready = 1 -> Pending = 8'h04 one cycle later; next cycle Output = 8'h02, Valid = 1, Pending = 8'h00.
- Ready = 0; pulse Input_8, Input_2, Input_5 together -> Output = 8'h01, Pending = 8'h90. Then Ready = 1 -> Output sequence 8'h01, 8'h04, 8'h07 on consecutive cycles, then Valid = 0.
- Ready = 0; pulse Input_4 twice with a low cycle between -> first pulse loaded (Output = 8'h03); second pulse sets Pending[3]; Overflow stays 0. A third pulse -> Overflow = 1; Clear for 1 cycle -> Overflow = 0.
- Hold Input_6 high through reset release -> exactly one event, Output = 8'h05; no further events while the line stays high.
- Assert rst while Valid = 1 and Pending = 8'h30 -> next cycle Valid = 0, Pending = 8'h00, Output = 8'h00, Overflow = 0.
- With ONEHOT8_ENC_ROUND_ROBIN_EN defined, Ready = 0: pulse Input_1, let Output = 8'h00 load, then pulse Input_1 and Input_2 together. Raise Ready -> codes 0, 1, 0. Without the macro the same stimulus gives 0, 0, 1.
